// File: rtl/blink_sched.sv
// Round-robin shared LED blink engine: NREQ requesters each ask for a
// burst of N on/off blinks; one burst runs at a time, then done pulses.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   req       level request, one bit per requester
//   req_cnt   blink count per requester, slice i at [i*NBITS +: NBITS]
//   half_per  cycles per LED phase (0 behaves as 1)
//   gnt       registered one-hot grant (zero when idle)
//   busy      engine owned by a requester
//   led       registered LED drive
//   flg       pulse on the last cycle of every on/off phase
//   done      pulse on the single completion cycle of a burst
module blink_sched #(
  parameter int NREQ  = 4,
  parameter int CBITS = 17,
  parameter int NBITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] req_cnt,
  input  logic [CBITS-1:0]      half_per,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  led,
  output logic                  flg,
  output logic                  done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [NREQ-1:0]  gnt_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [NBITS-1:0] rem, rem_n;
  logic [CBITS-1:0] pm1, pm1_n;
  logic [CBITS-1:0] cnt, cnt_n;
  logic             led_n;

  logic             hit;
  logic [PW-1:0]    pick;
  logic [PW-1:0]    idx;
  logic [NBITS-1:0] cnt_sel;
  logic             last;

  // Round-robin search starting just after the last winner.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!hit && req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  assign cnt_sel = req_cnt[pick*NBITS +: NBITS];

  // The phase length is stored as P-1 so a zero half_per maps to 1.
  assign last = (cnt == pm1);

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    ptr_n   = ptr;
    rem_n   = rem;
    pm1_n   = pm1;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        gnt_n = '0;
        if (hit) begin
          gnt_n = ONE << pick;
          ptr_n = pick;
          rem_n = cnt_sel;
          cnt_n = '0;
          pm1_n = (half_per == '0) ? '0
                : half_per - CBITS'(1);
          state_n = (cnt_sel != '0) ? ON : DONE;
        end
      end
      ON: begin
        if (last) begin
          cnt_n   = '0;
          state_n = OFF;
        end else begin
          cnt_n = cnt + CBITS'(1);
        end
      end
      OFF: begin
        if (last) begin
          cnt_n = '0;
          rem_n = rem - NBITS'(1);
          state_n = (rem == NBITS'(1)) ? DONE : ON;
        end else begin
          cnt_n = cnt + CBITS'(1);
        end
      end
      DONE: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
    led_n = (state_n == ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= PTR_RST;
      rem   <= '0;
      pm1   <= '0;
      cnt   <= '0;
      led   <= 1'b0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
      rem   <= rem_n;
      pm1   <= pm1_n;
      cnt   <= cnt_n;
      led   <= led_n;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign flg  = ((state == ON) || (state == OFF)) && last;

`ifndef SYNTHESIS
  a_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(gnt));
  a_led: assert property (
    @(posedge clk) disable iff (rst) led |-> (gnt != '0));
  a_busy: assert property (
    @(posedge clk) disable iff (rst) busy == (gnt != '0));
  a_done: assert property (
    @(posedge clk) disable iff (rst) done |=> !done);
`endif

endmodule

// File: tb/tb_blink_sched.sv
// Bench for blink_sched: per-cycle comparison against a burst-schedule
// model plus directed scenario checks with hand-computed counts.
module tb_blink_sched;

  localparam int NREQ  = 4;
  localparam int CBITS = 17;
  localparam int NBITS = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req = '0;
  logic [15:0]      req_cnt = '0;
  logic [16:0]      half_per = '0;
  logic [3:0]       gnt;
  logic             busy;
  logic             led;
  logic             flg;
  logic             done;

  blink_sched #(
    .NREQ (NREQ),
    .CBITS(CBITS),
    .NBITS(NBITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_cnt (req_cnt),
    .half_per(half_per),
    .gnt     (gnt),
    .busy    (busy),
    .led     (led),
    .flg     (flg),
    .done    (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: on each grant, the whole burst is expanded into a queue
  // of per-cycle frames {gnt, led, flg, done}.
  logic [6:0] q[$];
  logic [6:0] cur = '0;
  int         mptr = NREQ - 1;
  logic       chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur  = '0;
      mptr = NREQ - 1;
    end else if (cur[6:3] == 4'b0) begin
      int w;
      int p;
      int n;
      logic [3:0] g;
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (mptr + k) % NREQ;
        if (w < 0 && req[j]) w = j;
      end
      if (w >= 0) begin
        mptr = w;
        g = 4'b0001 << w;
        p = (half_per == 0) ? 1 : int'(half_per);
        n = int'(req_cnt[w*4 +: 4]);
        for (int b = 0; b < n; b++) begin
          for (int c = 0; c < p; c++)
            q.push_back({g, 1'b1, c == p - 1, 1'b0});
          for (int c = 0; c < p; c++)
            q.push_back({g, 1'b0, c == p - 1, 1'b0});
        end
        q.push_back({g, 3'b001});
        cur = q.pop_front();
      end else begin
        cur = '0;
      end
    end else begin
      cur = (q.size() > 0) ? q.pop_front() : 7'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] ev;
      logic [7:0] av;
      ev = {cur, cur[6:3] != 4'b0};
      av = {gnt, led, flg, done, busy};
      total++;
      if (av !== ev) begin
        bad++;
        $display("FAIL cycle t=%0t got gnt,led,flg,done,busy=%b want %b",
                 $time, av, ev);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int lim);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (!busy && gnt == 4'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL idle_timeout got busy=%b want 0", busy);
    end
  endtask

  logic [3:0] gv[256];
  logic       ledv[256];
  logic       flgv[256];
  logic       dv[256];
  int         nobs;

  task automatic observe(input int chg_at);
    nobs = 0;
    for (int i = 0; i < 250; i++) begin
      if (gnt == 4'b0) break;
      if (i == chg_at) begin
        half_per = 17'd1;
        req_cnt  = '0;
      end
      gv[nobs]   = gnt;
      ledv[nobs] = led;
      flgv[nobs] = flg;
      dv[nobs]   = done;
      nobs++;
      tick();
    end
    total++;
    if (gnt != 4'b0) begin
      bad++;
      $display("FAIL burst_timeout got gnt=%b want 0000", gnt);
    end
  endtask

  task automatic summarize(input string t, input logic [3:0] g,
                           input int len, input int lhi,
                           input int rises, input int flgs,
                           input int p);
    int nl;
    int nr;
    int nf;
    int nd;
    int ng;
    int pe;
    logic pl;
    nl = 0; nr = 0; nf = 0; nd = 0; ng = 0; pe = 0; pl = 1'b0;
    for (int i = 0; i < nobs; i++) begin
      if (gv[i] !== g) ng++;
      if (ledv[i]) nl++;
      if (ledv[i] && !pl) nr++;
      pl = ledv[i];
      if (flgv[i]) nf++;
      if (dv[i]) nd++;
      if (i < nobs - 1 && ledv[i] !== ((i / p) % 2 == 0)) pe++;
    end
    check({t, "_len"}, nobs, len);
    check({t, "_gnt_bad"}, ng, 0);
    check({t, "_led_hi"}, nl, lhi);
    check({t, "_rises"}, nr, rises);
    check({t, "_flg"}, nf, flgs);
    check({t, "_done_cnt"}, nd, 1);
    check({t, "_done_last"}, (nobs > 0) ? dv[nobs-1] : 1'b0, 1);
    check({t, "_pattern"}, pe, 0);
  endtask

  logic [3:0] gr[8];
  int         gap[8];
  int         ngr;
  int         zeros;
  logic [3:0] prev;
  logic [3:0] rr_exp[5];

  initial begin
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;

    // Reset held for two edges with every requester asking.
    rst = 1'b1;
    req = 4'b1111;
    req_cnt = 16'h1111;
    half_per = 17'd2;
    tick();
    chk_en = 1'b1;
    check("rst1_gnt", gnt, 0);
    check("rst1_led", led, 0);
    check("rst1_done", done, 0);
    tick();
    check("rst2_gnt", gnt, 0);
    check("rst2_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("first_gnt", gnt, 4'b0001);
    req = '0;
    wait_idle(50);

    // Single requester, three blinks of five cycles, inputs
    // disturbed mid-burst.
    req_cnt = 16'h0300;
    half_per = 17'd5;
    req = 4'b0100;
    tick();
    check("t2_latency", gnt, 4'b0100);
    req = '0;
    observe(7);
    summarize("t2", 4'b0100, 31, 15, 3, 6, 5);

    // Round-robin rotation from a fresh pointer.
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    req_cnt = 16'h1111;
    half_per = 17'd2;
    ngr = 0;
    zeros = 0;
    prev = 4'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (gnt != 4'b0 && prev == 4'b0) begin
        gr[ngr] = gnt;
        gap[ngr] = zeros;
        ngr++;
        zeros = 0;
        if (ngr == 5) break;
      end else if (gnt == 4'b0) begin
        zeros++;
      end
      prev = gnt;
    end
    req = '0;
    check("t3_ngrants", ngr, 5);
    for (int i = 0; i < ngr; i++)
      check("t3_order", gr[i], rr_exp[i]);
    for (int i = 1; i < ngr; i++)
      check("t3_gap", gap[i], 1);
    wait_idle(50);

    // Zero-count burst: grant and done in one cycle.
    req_cnt = 16'h0000;
    half_per = 17'd2;
    req = 4'b0010;
    tick();
    req = '0;
    check("t4_gnt", gnt, 4'b0010);
    check("t4_done", done, 1);
    observe(-1);
    summarize("t4", 4'b0010, 1, 0, 0, 0, 1);

    // half_per of zero behaves as one-cycle phases.
    req_cnt = 16'h0002;
    half_per = 17'd0;
    req = 4'b0001;
    tick();
    req = '0;
    observe(-1);
    summarize("t5", 4'b0001, 5, 2, 2, 4, 1);

    // Reset during the second on phase drops the burst.
    req_cnt = 16'h0003;
    half_per = 17'd3;
    req = 4'b0001;
    tick();
    check("t6_gnt", gnt, 4'b0001);
    req = '0;
    repeat (7) tick();
    check("t6_on2", led, 1);
    rst = 1'b1;
    tick();
    check("t6_rst_gnt", gnt, 0);
    check("t6_rst_led", led, 0);
    check("t6_rst_done", done, 0);
    rst = 1'b0;
    req = 4'b1111;
    req_cnt = 16'h1111;
    half_per = 17'd1;
    tick();
    check("t6_rr", gnt, 4'b0001);
    req = '0;
    wait_idle(50);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
